// File: rtl/fft_pkg.sv
// Shared constants, state encoding and the saturating absolute value helper
// used by the fundamental picker and the spectrum display path.
package fft_pkg;

    localparam int N_FFT = 1024;
    localparam int IDX_W = 10;
    localparam int DAT_W = 16;
    localparam int MAG_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

    // -32768 has no positive counterpart in 16 bits, so it clamps to 32767.
    function automatic logic [DAT_W-2:0] abs_sat(input logic signed [DAT_W-1:0] x);
        logic signed [DAT_W-1:0] neg;
        neg = -x;
        if (x == 16'sh8000) return 15'h7fff;
        return x[DAT_W-1] ? neg[DAT_W-2:0] : x[DAT_W-2:0];
    endfunction

endpackage

// File: rtl/fft_fundamental_pick_if.sv
// Streaming FFT input beats for both channels plus the picked-fundamental results.
interface fft_fundamental_pick_if;
    import fft_pkg::*;

    logic                    enable;
    logic                    fft_valid;
    logic                    fft_last;
    logic signed [DAT_W-1:0] fft_ch1_re;
    logic signed [DAT_W-1:0] fft_ch1_im;
    logic signed [DAT_W-1:0] fft_ch2_re;
    logic signed [DAT_W-1:0] fft_ch2_im;

    logic signed [DAT_W-1:0] ch1_re;
    logic signed [DAT_W-1:0] ch1_im;
    logic signed [DAT_W-1:0] ch2_re;
    logic signed [DAT_W-1:0] ch2_im;
    logic                    ch1_valid;
    logic                    ch2_valid;
    logic [IDX_W-1:0]        peak_bin;
    logic [MAG_W-1:0]        peak_mag;
    logic                    no_signal;
    logic                    frame_err;

    modport master (
        output enable, fft_valid, fft_last, fft_ch1_re, fft_ch1_im, fft_ch2_re, fft_ch2_im,
        input  ch1_re, ch1_im, ch2_re, ch2_im, ch1_valid, ch2_valid,
        input  peak_bin, peak_mag, no_signal, frame_err
    );

    modport slave (
        input  enable, fft_valid, fft_last, fft_ch1_re, fft_ch1_im, fft_ch2_re, fft_ch2_im,
        output ch1_re, ch1_im, ch2_re, ch2_im, ch1_valid, ch2_valid,
        output peak_bin, peak_mag, no_signal, frame_err
    );

endinterface

// File: rtl/cplx_mag_l1.sv
// Registered L1 magnitude |re|+|im| of a complex sample with saturating abs.
module cplx_mag_l1
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic signed [DAT_W-1:0] re_i,
    input  logic signed [DAT_W-1:0] im_i,
    output logic [MAG_W-1:0]        mag_o
);

    logic [MAG_W-1:0] mag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
        end else if (en_i) begin
            mag_q <= {2'b00, abs_sat(re_i)} + {2'b00, abs_sat(im_i)};
        end
    end

    assign mag_o = mag_q;

endmodule

// File: rtl/fft_fundamental_pick.sv
// Picks the peak-magnitude ch1 bin inside the search window each frame and
// emits both channels' complex values at that bin three cycles after the last beat.
module fft_fundamental_pick
    import fft_pkg::*;
#(
    parameter int MIN_BIN    = 2,
    parameter int MAX_BIN    = 511,
    parameter int MAG_THRESH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_fundamental_pick_if.slave bus
);

    localparam logic [IDX_W-1:0] MIN_IDX  = IDX_W'(MIN_BIN);
    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_BIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FFT - 1);
    localparam logic [MAG_W-1:0] MAG_THR  = MAG_W'(MAG_THRESH);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             beat, frame_end, len_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat      = 1'b0;
        frame_end = 1'b0;
        len_err   = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (bus.fft_valid && bus.fft_last) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end
                end
                ST_SCAN: begin
                    if (bus.fft_valid) begin
                        beat = 1'b1;
                        if (bus.fft_last) begin
                            frame_end = 1'b1;
                            len_err   = (cnt_q != LAST_IDX);
                            cnt_d     = '0;
                        end else if (cnt_q == LAST_IDX) begin
                            // Full frame seen without a last marker: lose lock.
                            frame_end = 1'b1;
                            len_err   = 1'b1;
                            cnt_d     = '0;
                            state_d   = ST_SYNC;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage 1: magnitude plus the raw sample and frame position flags.
    logic [MAG_W-1:0]        s1_mag;
    logic                    s1_vld_q, s1_first_q, s1_last_q, s1_err_q, s1_win_q;
    logic [IDX_W-1:0]        s1_idx_q;
    logic signed [DAT_W-1:0] s1_c1re_q, s1_c1im_q, s1_c2re_q, s1_c2im_q;

    cplx_mag_l1 u_mag (
        .clk   (clk),
        .rst   (rst),
        .en_i  (beat),
        .re_i  (bus.fft_ch1_re),
        .im_i  (bus.fft_ch1_im),
        .mag_o (s1_mag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_win_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_c1re_q  <= '0;
            s1_c1im_q  <= '0;
            s1_c2re_q  <= '0;
            s1_c2im_q  <= '0;
        end else begin
            s1_vld_q <= beat;
            if (beat) begin
                s1_first_q <= (cnt_q == '0);
                s1_last_q  <= frame_end;
                s1_err_q   <= len_err;
                s1_win_q   <= (cnt_q >= MIN_IDX) && (cnt_q <= MAX_IDX);
                s1_idx_q   <= cnt_q;
                s1_c1re_q  <= bus.fft_ch1_re;
                s1_c1im_q  <= bus.fft_ch1_im;
                s1_c2re_q  <= bus.fft_ch2_re;
                s1_c2im_q  <= bus.fft_ch2_im;
            end
        end
    end

    // Stage 2: running best; strict greater-than keeps the lowest bin on ties.
    logic                    take, clear_best;
    logic [MAG_W-1:0]        best_mag_q;
    logic [IDX_W-1:0]        best_idx_q;
    logic signed [DAT_W-1:0] best_c1re_q, best_c1im_q, best_c2re_q, best_c2im_q;
    logic                    done_q, done_err_q;

    assign take       = s1_vld_q && s1_win_q && (s1_first_q || (s1_mag > best_mag_q));
    assign clear_best = s1_vld_q && s1_first_q && !s1_win_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_mag_q  <= '0;
            best_idx_q  <= '0;
            best_c1re_q <= '0;
            best_c1im_q <= '0;
            best_c2re_q <= '0;
            best_c2im_q <= '0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            if (take) begin
                best_mag_q  <= s1_mag;
                best_idx_q  <= s1_idx_q;
                best_c1re_q <= s1_c1re_q;
                best_c1im_q <= s1_c1im_q;
                best_c2re_q <= s1_c2re_q;
                best_c2im_q <= s1_c2im_q;
            end else if (clear_best) begin
                best_mag_q <= '0;
            end
            done_q     <= s1_vld_q && s1_last_q && bus.enable;
            done_err_q <= s1_err_q;
        end
    end

    // Output stage.
    logic                    hit;
    logic                    valid_q, nosig_q, ferr_q;
    logic [MAG_W-1:0]        out_mag_q;
    logic [IDX_W-1:0]        out_idx_q;
    logic signed [DAT_W-1:0] out_c1re_q, out_c1im_q, out_c2re_q, out_c2im_q;

    assign hit = done_q && bus.enable && !done_err_q && (best_mag_q >= MAG_THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            nosig_q    <= 1'b0;
            ferr_q     <= 1'b0;
            out_mag_q  <= '0;
            out_idx_q  <= '0;
            out_c1re_q <= '0;
            out_c1im_q <= '0;
            out_c2re_q <= '0;
            out_c2im_q <= '0;
        end else begin
            valid_q <= hit;
            nosig_q <= done_q && bus.enable && !done_err_q && (best_mag_q < MAG_THR);
            ferr_q  <= done_q && bus.enable && done_err_q;
            if (hit) begin
                out_mag_q  <= best_mag_q;
                out_idx_q  <= best_idx_q;
                out_c1re_q <= best_c1re_q;
                out_c1im_q <= best_c1im_q;
                out_c2re_q <= best_c2re_q;
                out_c2im_q <= best_c2im_q;
            end
        end
    end

    assign bus.ch1_re    = out_c1re_q;
    assign bus.ch1_im    = out_c1im_q;
    assign bus.ch2_re    = out_c2re_q;
    assign bus.ch2_im    = out_c2im_q;
    assign bus.ch1_valid = valid_q;
    assign bus.ch2_valid = valid_q;
    assign bus.peak_bin  = out_idx_q;
    assign bus.peak_mag  = out_mag_q;
    assign bus.no_signal = nosig_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_fft_fundamental_pick.sv
// Directed frames against hand-computed peak bins, magnitudes and pulse timing.
module tb_fft_fundamental_pick;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fft_fundamental_pick_if bus ();

    fft_fundamental_pick dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [15:0] a1r [1024];
    logic signed [15:0] a1i [1024];
    logic signed [15:0] a2r [1024];
    logic signed [15:0] a2i [1024];

    int n_val = 0, n_ns = 0, n_err = 0;
    int v_cyc = 0, pv_cyc = 0, ns_cyc = 0, e_cyc = 0;
    int v_bin = 0, pv_bin = 0;
    int last_cyc = 0;
    int exp_val = 0, exp_ns = 0, exp_err = 0;
    int l1 = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ch1_valid || bus.ch2_valid)
            chk("valid_coincident", 32'(bus.ch2_valid), 32'(bus.ch1_valid));
        if (bus.ch1_valid) begin
            n_val++;
            pv_cyc = v_cyc;
            pv_bin = v_bin;
            v_cyc  = cyc;
            v_bin  = int'(bus.peak_bin);
        end
        if (bus.no_signal) begin
            n_ns++;
            ns_cyc = cyc;
        end
        if (bus.frame_err) begin
            n_err++;
            e_cyc = cyc;
        end
    end

    task automatic clr();
        for (int i = 0; i < 1024; i++) begin
            a1r[i] = '0; a1i[i] = '0; a2r[i] = '0; a2i[i] = '0;
        end
    endtask

    task automatic put(input int b, input int r1, input int i1, input int r2, input int i2);
        a1r[b[9:0]] = 16'(r1);
        a1i[b[9:0]] = 16'(i1);
        a2r[b[9:0]] = 16'(r2);
        a2i[b[9:0]] = 16'(i2);
    endtask

    task automatic idle(input int n);
        bus.fft_valid = 1'b0;
        bus.fft_last  = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int nbeats, input int last_at, input bit gaps);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && (i % 97) == 50) begin
                bus.fft_valid = 1'b0;
                bus.fft_last  = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.fft_valid  = 1'b1;
            bus.fft_last   = (i == last_at);
            bus.fft_ch1_re = a1r[i[9:0]];
            bus.fft_ch1_im = a1i[i[9:0]];
            bus.fft_ch2_re = a2r[i[9:0]];
            bus.fft_ch2_im = a2i[i[9:0]];
            last_cyc       = cyc;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_nval"}, n_val, exp_val);
        chk({tag, "_nns"},  n_ns,  exp_ns);
        chk({tag, "_nerr"}, n_err, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.fft_valid = 1'b0;
        bus.fft_last = 1'b0;
        bus.fft_ch1_re = '0; bus.fft_ch1_im = '0;
        bus.fft_ch2_re = '0; bus.fft_ch2_im = '0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ch1_re", $signed(bus.ch1_re), 0);
        chk("rst_peak_bin", 32'(bus.peak_bin), 0);
        chk("rst_peak_mag", 32'(bus.peak_mag), 0);
        chk("rst_valid", 32'(bus.ch1_valid), 0);
        chk("rst_flags", 32'({bus.no_signal, bus.frame_err}), 0);
        rst = 1'b0;

        bus.enable = 1'b1;
        idle(2);
        send(1, 0, 1'b0);
        idle(6);
        chk_counts("sync");

        // Tone at bin 10, frame with gaps
        clr(); put(10, 1000, 0, 0, 1000);
        send(1024, 1023, 1'b1); idle(6);
        exp_val++;
        chk_counts("tone");
        chk("tone_latency", v_cyc, last_cyc + 3);
        chk("tone_ch1_re", $signed(bus.ch1_re), 1000);
        chk("tone_ch1_im", $signed(bus.ch1_im), 0);
        chk("tone_ch2_re", $signed(bus.ch2_re), 0);
        chk("tone_ch2_im", $signed(bus.ch2_im), 1000);
        chk("tone_bin", 32'(bus.peak_bin), 10);
        chk("tone_mag", 32'(bus.peak_mag), 1000);

        // DC and out-of-window bins rejected
        clr(); put(0, 20000, 0, 0, 0); put(1, 1000, 0, 0, 0); put(512, 5000, 0, 0, 0);
        put(511, 600, 0, 0, 0); put(7, -300, -400, 5, -6);
        send(1024, 1023, 1'b0); idle(6);
        exp_val++;
        chk_counts("dc");
        chk("dc_bin", 32'(bus.peak_bin), 7);
        chk("dc_mag", 32'(bus.peak_mag), 700);
        chk("dc_ch1_re", $signed(bus.ch1_re), -300);
        chk("dc_ch1_im", $signed(bus.ch1_im), -400);
        chk("dc_ch2_im", $signed(bus.ch2_im), -6);

        // Tie and saturation
        clr(); put(5, -32768, 0, 11, 0); put(9, -32768, 0, 22, 0);
        send(1024, 1023, 1'b0); idle(6);
        exp_val++;
        chk_counts("tie");
        chk("tie_bin", 32'(bus.peak_bin), 5);
        chk("tie_mag", 32'(bus.peak_mag), 32767);
        chk("tie_ch2_re", $signed(bus.ch2_re), 11);
        chk("tie_ch1_re", $signed(bus.ch1_re), -32768);

        // Short frame then a good one
        clr(); put(20, 700, 0, 3, 4);
        send(501, 500, 1'b0); l1 = last_cyc; idle(6);
        exp_err++;
        chk_counts("short");
        chk("short_latency", e_cyc, l1 + 3);
        chk("short_held_bin", 32'(bus.peak_bin), 5);
        send(1024, 1023, 1'b0); idle(6);
        exp_val++;
        chk_counts("good");
        chk("good_bin", 32'(bus.peak_bin), 20);
        chk("good_ch2_im", $signed(bus.ch2_im), 4);

        // Weak signal
        clr(); put(15, 30, 20, 0, 0);
        send(1024, 1023, 1'b0); idle(6);
        exp_ns++;
        chk_counts("weak");
        chk("weak_latency", ns_cyc, last_cyc + 3);
        chk("weak_held_bin", 32'(bus.peak_bin), 20);
        chk("weak_held_mag", 32'(bus.peak_mag), 700);

        // Back-to-back frames
        clr(); put(12, 500, 0, 0, 0);
        send(1024, 1023, 1'b0);
        clr(); put(40, 0, -900, 0, 0);
        send(1024, 1023, 1'b0); idle(6);
        exp_val += 2;
        chk_counts("b2b");
        chk("b2b_spacing", v_cyc - pv_cyc, 1024);
        chk("b2b_first_bin", pv_bin, 12);
        chk("b2b_second_bin", v_bin, 40);
        chk("b2b_mag", 32'(bus.peak_mag), 900);

        // Overrun without fft_last, then resync
        clr();
        send(1024, -1, 1'b0); idle(6);
        exp_err++;
        chk_counts("overrun");
        chk("overrun_latency", e_cyc, last_cyc + 3);
        clr(); put(3, 5000, 0, 0, 0);
        send(1024, 1023, 1'b0); idle(6);
        chk_counts("resync");
        chk("resync_held_bin", 32'(bus.peak_bin), 40);
        clr(); put(33, 800, 0, 0, 0);
        send(1024, 1023, 1'b0); idle(6);
        exp_val++;
        chk_counts("after_resync");
        chk("after_resync_bin", 32'(bus.peak_bin), 33);

        // Enable dropped mid-frame
        clr(); put(100, 4000, 0, 0, 0);
        send(300, -1, 1'b0);
        bus.enable = 1'b0;
        idle(4);
        bus.enable = 1'b1;
        idle(2);
        send(1024, 1023, 1'b0); idle(6);
        chk_counts("en_drop");
        chk("en_drop_held_bin", 32'(bus.peak_bin), 33);
        send(1024, 1023, 1'b0); idle(6);
        exp_val++;
        chk_counts("en_resume");
        chk("en_resume_bin", 32'(bus.peak_bin), 100);
        chk("en_resume_mag", 32'(bus.peak_mag), 4000);

        // Reset mid-frame
        send(300, -1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_ch1_re", $signed(bus.ch1_re), 0);
        chk("midrst_ch2_im", $signed(bus.ch2_im), 0);
        chk("midrst_bin", 32'(bus.peak_bin), 0);
        chk("midrst_mag", 32'(bus.peak_mag), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        chk_counts("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_fundamental_pick.md
Name: fft_fundamental_pick

Overview:
Upstream neighbour of the dual-channel phase-difference calculator.
- Consumes the streamed FFT output of both channels, which arrive bin-aligned on the same beat.
- Finds the fundamental as the peak-magnitude bin of channel 1 within a search window.
- At end of frame, emits the complex value of that bin for both channels (ch1/ch2 re, im, valid), ready for the atan2 and phase-difference stage.
- Also reports the peak bin index and magnitude for frequency display.

Parameters:
N_FFT, 1024, FFT length (bins per frame, power of two)
IDX_W, 10, bin index width, equal to log2(N_FFT)
MIN_BIN, 2, lowest bin searched (excludes DC/leakage)
MAX_BIN, 511, highest bin searched (positive half-spectrum)
MAG_THRESH, 64, minimum peak |re|+|im| for a valid output

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  search enable
fft_valid  in  1  input beat valid, no backpressure
fft_last  in  1  marks bin N_FFT-1 of a frame
fft_ch1_re  in  16  signed, channel 1 real
fft_ch1_im  in  16  signed, channel 1 imaginary
fft_ch2_re  in  16  signed, channel 2 real
fft_ch2_im  in  16  signed, channel 2 imaginary
ch1_re, ch1_im  out  16 each  signed, ch1 value at peak bin
ch2_re, ch2_im  out  16 each  signed, ch2 value at the same bin
ch1_valid, ch2_valid  out  1  one-cycle pulses, always coincident
peak_bin  out  IDX_W  index of the detected fundamental
peak_mag  out  17  |re|+|im| of ch1 at peak_bin
no_signal  out  1  one-cycle pulse: frame complete but peak < MAG_THRESH
frame_err  out  1  one-cycle pulse: frame length mismatch

Behaviour:
- Reset: all outputs 0, FSM in IDLE, bin counter 0, best-magnitude register 0.
- FSM states:
  - IDLE: enable=0, beats ignored. enable=1 -> SYNC.
  - SYNC: wait for a beat with fft_valid&fft_last, then -> SCAN. The next beat is bin 0.
  - SCAN: each fft_valid beat increments the bin counter.
  - enable=0 in any state -> IDLE next cycle. The partial frame is discarded, in-flight pipeline flags are cleared, and no valid/err pulse is generated.
- Pipeline (fully streaming, accepts back-to-back frames):
  - Stage 1 registers |re|+|im| of ch1 (17-bit), the four raw inputs, the bin index, and first/last/in_window flags.
  - Absolute value of -32768 saturates to 32767.
  - Stage 2 compares against the best register.
    - On a first beat, best is loaded unconditionally if in window, else cleared to 0.
    - Otherwise best is updated only if in_window && mag > best (strict greater-than, so ties keep the lowest bin).
    - The captured value includes the ch1/ch2 re/im and the index.
  - Output register: on a stage-2 last beat, outputs are updated from the final best (including the last beat itself).
- Latency: last beat accepted at cycle T -> valid/no_signal/frame_err asserted at T+3 for exactly one cycle.
- Output hold: ch*/peak_* hold their value until the next successful frame. No update on no_signal or frame_err.
- Threshold: final best < MAG_THRESH -> no_signal=1, valids stay 0.
- Window: in_window = MIN_BIN <= idx <= MAX_BIN. No candidate ever qualifies (all magnitudes 0) -> no_signal.
- Frame length errors:
  - fft_last arrives with counter != N_FFT-1 -> frame_err at T+3, no valid. Counter restarts at 0, staying in SCAN.
  - Counter reaches N_FFT-1 without fft_last -> frame_err at that beat+3, -> SYNC.
- Gaps: fft_valid gaps inside a frame are allowed; counter and pipeline advance only on valid beats.
- Reset mid-frame: immediate clear, no spurious pulses after release.

Decomposition:
- Shared package fft_pkg: N_FFT, IDX_W, the 17-bit magnitude width constant, and the FSM state encoding (IDLE/SYNC/SCAN).
- One natural sub-module: cplx_mag_l1, a registered |re|+|im| with saturating abs, reusable by the spectrum display path.

Test Plan:
- Tone at bin 10: ch1=(1000,0), ch2=(0,1000), all other bins 0; enable, sync frame, then one full frame -> valids at last+3 with ch1=(1000,0), ch2=(0,1000), peak_bin=10, peak_mag=1000.
- DC rejection: bin 0 ch1=(20000,0), bin 7 ch1=(-300,-400) -> peak_bin=7, peak_mag=700, ch1=(-300,-400).
- Tie and saturation: bins 5 and 9 both ch1=(-32768,0) -> peak_bin=5, peak_mag=32767.
- Short frame (fft_last on beat 500), then a good frame with peak at bin 20 -> frame_err pulse only, then a valid pulse with peak_bin=20. Outputs unchanged between the two.
- Weak signal: peak ch1=(30,20), i.e. magnitude 50 < 64 -> no_signal pulse, valids 0, previous outputs held.
- Back-to-back frames with peaks at 12 then 40, no gaps -> two valid pulses exactly N_FFT cycles apart with peak_bin 12, 40.
- Disturbances mid-frame:
  - enable dropped at beat 300 -> no pulses; re-enable requires a SYNC frame.
  - rst at beat 300 -> all outputs 0.
